// File: rtl/param_updown_counter_if.sv
// Control and status bundle for param_updown_counter.
// master drives the strobes, slave is the counter itself.
interface param_updown_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             wrap;

  modport master (
    output en, up_dn, load, load_val,
    input  count, tc, wrap
  );

  modport slave (
    input  en, up_dn, load, load_val,
    output count, tc, wrap
  );
endinterface

// File: rtl/param_updown_counter.sv
// Synchronous up/down modulo counter with load, enable, tc and wrap pulse.
// Define COUNTER_SATURATE_EN to saturate at the ends instead of wrapping.
module param_updown_counter #(
  parameter int WIDTH     = 4,
  parameter int MODULO    = 16,
  parameter int RESET_VAL = 0
) (
  input logic                  clk,
  input logic                  rst,
  param_updown_counter_if.slave bus
);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULO - 1);
  localparam logic [WIDTH-1:0] RV  = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0] ld_val;
  logic             at_max;
  logic             at_zero;
  logic             do_load;
  logic             do_up;
  logic             do_dn;

  assign at_max  = (cnt_q == MAX);
  assign at_zero = (cnt_q == '0);
  assign ld_val  = (bus.load_val > MAX) ? MAX : bus.load_val;

  // Mutually exclusive strobes; load masks the enable.
  assign do_load = bus.load;
  assign do_up   = ~bus.load & bus.en & bus.up_dn;
  assign do_dn   = ~bus.load & bus.en & ~bus.up_dn;

`ifdef COUNTER_SATURATE_EN
  always_comb begin
    cnt_d = cnt_q;
    unique case (1'b1)
      do_load: cnt_d = ld_val;
      do_up: begin
        if (!at_max) cnt_d = cnt_q + WIDTH'(1);
      end
      do_dn: begin
        if (!at_zero) cnt_d = cnt_q - WIDTH'(1);
      end
      default: cnt_d = cnt_q;
    endcase
  end

  assign bus.wrap = 1'b0;
`else
  logic wrap_q;
  logic wrap_d;

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    unique case (1'b1)
      do_load: cnt_d = ld_val;
      do_up: begin
        if (at_max) begin
          cnt_d  = '0;
          wrap_d = 1'b1;
        end else begin
          cnt_d  = cnt_q + WIDTH'(1);
        end
      end
      do_dn: begin
        if (at_zero) begin
          cnt_d  = MAX;
          wrap_d = 1'b1;
        end else begin
          cnt_d  = cnt_q - WIDTH'(1);
        end
      end
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) wrap_q <= 1'b0;
    else     wrap_q <= wrap_d;
  end

  assign bus.wrap = wrap_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= RV;
    else     cnt_q <= cnt_d;
  end

  assign bus.count = cnt_q;
  assign bus.tc    = bus.en &
                     ((bus.up_dn & at_max) |
                      (~bus.up_dn & at_zero));
endmodule

// File: tb/tb_param_updown_counter.sv
// Directed bench for param_updown_counter: two instances
// (MODULO=10/RESET_VAL=0 and MODULO=16/RESET_VAL=3) with a scoreboard.
module tb_param_updown_counter;
  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;

  always #5 clk = ~clk;

  param_updown_counter_if #(.WIDTH(4)) ia ();
  param_updown_counter_if #(.WIDTH(4)) ib ();

  param_updown_counter #(
    .WIDTH(4), .MODULO(10), .RESET_VAL(0)
  ) dut_a (
    .clk(clk), .rst(rst_a), .bus(ia.slave)
  );

  param_updown_counter #(
    .WIDTH(4), .MODULO(16), .RESET_VAL(3)
  ) dut_b (
    .clk(clk), .rst(rst_b), .bus(ib.slave)
  );

  typedef struct {
    bit         sel;
    logic [3:0] cnt;
    logic       wrap;
  } sb_t;

  sb_t sbq[$];

  int vectors = 0;
  int errs    = 0;

  logic [3:0] ma = 4'd0;
  logic [3:0] mb = 4'd0;

  // Reference next-state: {wrap, count}
  function automatic logic [4:0] mnext(
    input int mod, input int rv, input logic [3:0] c,
    input logic r, input logic l, input logic [3:0] lv,
    input logic e, input logic ud);
    logic [3:0] mx;
    mx = 4'(mod - 1);
    if (r) return {1'b0, 4'(rv)};
    if (l) return {1'b0, (int'(lv) >= mod) ? mx : lv};
    if (!e) return {1'b0, c};
    if (ud) begin
      if (c != mx) return {1'b0, 4'(c + 4'd1)};
`ifdef COUNTER_SATURATE_EN
      return {1'b0, c};
`else
      return {1'b1, 4'd0};
`endif
    end
    if (c != 4'd0) return {1'b0, 4'(c - 4'd1)};
`ifdef COUNTER_SATURATE_EN
    return {1'b0, c};
`else
    return {1'b1, mx};
`endif
  endfunction

  task automatic step(input bit sel, input logic r, input logic l,
                      input logic [3:0] lv, input logic e,
                      input logic ud);
    logic [3:0] c;
    logic [4:0] nx;
    logic       tce;
    logic       tco;
    logic [3:0] co;
    logic       wo;
    int         mod;
    int         rv;
    sb_t        s;
    @(negedge clk);
    if (!sel) begin
      rst_a = r; ia.load = l; ia.load_val = lv;
      ia.en = e; ia.up_dn = ud;
    end else begin
      rst_b = r; ib.load = l; ib.load_val = lv;
      ib.en = e; ib.up_dn = ud;
    end
    #1;
    c   = sel ? mb : ma;
    mod = sel ? 16 : 10;
    rv  = sel ? 3 : 0;
    tce = e & ((ud & (c == 4'(mod - 1))) | (~ud & (c == 4'd0)));
    tco = sel ? ib.tc : ia.tc;
    vectors++;
    assert (tco === tce) else begin
      errs++;
      $error("FAIL tc%0d cnt=%0d obs=%b exp=%b", sel, c, tco, tce);
    end
    nx = mnext(mod, rv, c, r, l, lv, e, ud);
    sbq.push_back('{sel: sel, cnt: nx[3:0], wrap: nx[4]});
    if (sel) mb = nx[3:0];
    else     ma = nx[3:0];
    @(posedge clk);
    #1;
    s  = sbq.pop_front();
    co = s.sel ? ib.count : ia.count;
    wo = s.sel ? ib.wrap  : ia.wrap;
    vectors++;
    assert (co === s.cnt) else begin
      errs++;
      $error("FAIL count%0d obs=%0d exp=%0d", s.sel, co, s.cnt);
    end
    vectors++;
    assert (wo === s.wrap) else begin
      errs++;
      $error("FAIL wrap%0d obs=%b exp=%b", s.sel, wo, s.wrap);
    end
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    ia.load = 1'b0; ia.load_val = 4'd0; ia.en = 1'b0; ia.up_dn = 1'b1;
    ib.load = 1'b0; ib.load_val = 4'd0; ib.en = 1'b0; ib.up_dn = 1'b1;

    // A: reset then up count through the wrap
    step(0, 1, 0, 4'd0, 0, 1);
    step(0, 1, 0, 4'd0, 0, 1);
    for (int i = 0; i < 12; i++) step(0, 0, 0, 4'd0, 1, 1);

    // A: load 2 then down through zero
    step(0, 0, 1, 4'd2, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 4'd0, 1, 0);

    // A: load clamp with en, then rst beats load
    step(0, 0, 1, 4'd13, 1, 1);
    step(0, 0, 0, 4'd0, 0, 1);
    step(0, 1, 1, 4'd7, 1, 1);
    step(0, 0, 1, 4'd15, 0, 0);

    // A: hold at 4, then direction toggling
    step(0, 0, 1, 4'd4, 0, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 4'd0, 0, i[0]);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 4'd0, 1, ~i[0]);

    // A: saturation / wrap at the top and bottom
    step(0, 0, 1, 4'd8, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 4'd0, 1, 1);
    step(0, 0, 1, 4'd1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 4'd0, 1, 0);

    // B: reset to 3, count to 7, mid-count reset
    step(1, 1, 0, 4'd0, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 4'd0, 1, 1);
    step(1, 1, 0, 4'd0, 1, 1);
    step(1, 0, 0, 4'd0, 1, 1);
    step(1, 0, 0, 4'd0, 1, 1);

    // B: full-range overflow/underflow
    step(1, 0, 1, 4'd14, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 4'd0, 1, 1);
    step(1, 0, 1, 4'd0, 0, 0);
    for (int i = 0; i < 2; i++) step(1, 0, 0, 4'd0, 1, 0);

    vectors++;
    assert (sbq.size() == 0) else begin
      errs++;
      $error("FAIL sbq obs=%0d exp=0", sbq.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
